// File: rtl/hssim_pkg.sv
// Shared constants and helpers for the HSSIM consumer blocks: beat geometry and
// the decision-map popcount used by the optional frame statistics.
package hssim_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned MAX_PPB = 64;

  typedef logic [PIX_W-1:0] pixel_t;

  function automatic int unsigned beats_per_frame(input int unsigned dim,
                                                  input int unsigned ppb);
    return (dim * dim) / ppb;
  endfunction

  // Counts decision bytes whose MSB is set among the low n bytes of a beat.
  function automatic int unsigned msb_popcount(input logic [PIX_W*MAX_PPB-1:0] bytes,
                                               input int unsigned n);
    int unsigned c;
    c = 0;
    for (int unsigned j = 0; j < MAX_PPB; j++) begin
      if (j < n && bytes[j*PIX_W + PIX_W - 1]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/hssim_pair_fifo.sv
// Synchronous FIFO of {old,new} pixel-beat pairs with occupancy count.
// No bypass: a pushed entry becomes readable the cycle after its push.
module hssim_pair_fifo #(
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  wdata,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  rdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap modulo FIFO_DEPTH, which need not be a power of two.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/hssim_fuse.sv
// Fuses buffered old/new pixel beats under the HSSIM decision map into a framed
// ready/valid stream. Define HSSIM_FUSE_STATS_EN to add per-frame change counts.
module hssim_fuse
  import hssim_pkg::*;
#(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned FIFO_DEPTH      = 32
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [PIX_W*PIXELS_PER_BEAT-1:0]     s_old,
  input  logic [PIX_W*PIXELS_PER_BEAT-1:0]     s_new,
  input  logic                                 del_valid,
  input  logic [PIX_W*PIXELS_PER_BEAT-1:0]     del,
  output logic                                 stall,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic [PIX_W*PIXELS_PER_BEAT-1:0]     m_tdata,
  output logic                                 m_tuser,
  output logic                                 m_tlast,
  output logic                                 err_underflow
`ifdef HSSIM_FUSE_STATS_EN
  ,
  output logic [$clog2(IMAGE_DIM*IMAGE_DIM+1)-1:0] frame_changes,
  output logic                                 frame_changes_valid
`endif
);

  localparam int unsigned BW  = PIX_W * PIXELS_PER_BEAT;
  localparam int unsigned BPF = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int unsigned BCW = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]   count;
  logic [2*BW-1:0] rd_pair;
  logic [BW-1:0]   rd_old;
  logic [BW-1:0]   rd_new;
  logic [BW-1:0]   fused;
  logic            push;
  logic            pop;
  logic            underflow;
  logic [BCW-1:0]  beat_cnt;
  logic            first_beat;
  logic            last_beat;
  logic            unused_del_bits;

  assign stall     = m_tvalid & ~m_tready;
  assign s_ready   = ~stall & (count < CW'(FIFO_DEPTH));
  assign push      = s_valid & s_ready;
  assign pop       = del_valid & ~stall & (count != '0);
  assign underflow = del_valid & ~stall & (count == '0);

  assign {rd_old, rd_new} = rd_pair;
  assign unused_del_bits  = ^del;

  hssim_pair_fifo #(
    .WIDTH      (2 * BW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .push    (push),
    .wdata   ({s_old, s_new}),
    .pop     (pop),
    .rdata   (rd_pair),
    .count   (count)
  );

  // Only the MSB of each decision byte selects between new and old pixel.
  always_comb begin
    fused = '0;
    for (int unsigned j = 0; j < PIXELS_PER_BEAT; j++) begin
      fused[j*PIX_W +: PIX_W] = del[j*PIX_W + PIX_W - 1] ? rd_new[j*PIX_W +: PIX_W]
                                                        : rd_old[j*PIX_W +: PIX_W];
    end
  end

  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == BCW'(BPF - 1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid      <= 1'b0;
      m_tdata       <= '0;
      m_tuser       <= 1'b0;
      m_tlast       <= 1'b0;
      beat_cnt      <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (pop) begin
        m_tvalid <= 1'b1;
        m_tdata  <= fused;
        m_tuser  <= first_beat;
        m_tlast  <= last_beat;
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (underflow) err_underflow <= 1'b1;
    end
  end

`ifdef HSSIM_FUSE_STATS_EN
  localparam int unsigned FCW  = $clog2(IMAGE_DIM * IMAGE_DIM + 1);
  localparam int unsigned EXTW = PIX_W * MAX_PPB;

  logic [EXTW-1:0] del_ext;
  logic [FCW-1:0]  beat_changes;
  logic [FCW-1:0]  acc;
  logic [FCW-1:0]  acc_next;

  assign del_ext      = EXTW'(del);
  assign beat_changes = FCW'(msb_popcount(del_ext, PIXELS_PER_BEAT));
  assign acc_next     = first_beat ? beat_changes : acc + beat_changes;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc                 <= '0;
      frame_changes       <= '0;
      frame_changes_valid <= 1'b0;
    end else begin
      frame_changes_valid <= pop & last_beat;
      if (pop) acc <= acc_next;
      if (pop && last_beat) frame_changes <= acc_next;
    end
  end
`endif

endmodule

// File: tb/tb_hssim_fuse.sv
// Self-checking bench for hssim_fuse: vector table plus hand-written corner
// sequences, with a cycle model feeding an output scoreboard.
module tb_hssim_fuse;

  localparam int unsigned PPB   = 16;
  localparam int unsigned DIM   = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned W     = 8 * PPB;
  localparam int unsigned BPF   = DIM * DIM / PPB;
  localparam int unsigned FCW   = $clog2(DIM * DIM + 1);

  logic         clk = 1'b0;
  logic         aresetn = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_old = '0;
  logic [W-1:0] s_new = '0;
  logic         del_valid = 1'b0;
  logic [W-1:0] del = '0;
  logic         stall;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic [W-1:0] m_tdata;
  logic         m_tuser;
  logic         m_tlast;
  logic         err_underflow;
`ifdef HSSIM_FUSE_STATS_EN
  logic [FCW-1:0] frame_changes;
  logic           frame_changes_valid;
`endif

  always #5 clk = ~clk;

  hssim_fuse #(
    .PIXELS_PER_BEAT (PPB),
    .IMAGE_DIM       (DIM),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_old         (s_old),
    .s_new         (s_new),
    .del_valid     (del_valid),
    .del           (del),
    .stall         (stall),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tdata       (m_tdata),
    .m_tuser       (m_tuser),
    .m_tlast       (m_tlast),
    .err_underflow (err_underflow)
`ifdef HSSIM_FUSE_STATS_EN
    ,
    .frame_changes       (frame_changes),
    .frame_changes_valid (frame_changes_valid)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    logic         user;
    logic         last;
  } exp_t;

  typedef struct {
    logic [W-1:0] old_px;
    logic [W-1:0] new_px;
    logic [W-1:0] del;
    logic [W-1:0] exp;
  } vec_t;

  exp_t           sb[$];
  logic [2*W-1:0] mq[$];
  logic           mv = 1'b0;
  logic           merr = 1'b0;
  logic           mfcv = 1'b0;
  logic           last_pop = 1'b0;
  int unsigned    mbeat = 0;
  int unsigned    macc = 0;
  int unsigned    mfc = 0;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] tb_fuse(input logic [W-1:0] o, input logic [W-1:0] n,
                                           input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int j = 0; j < PPB; j++) r[8*j +: 8] = d[8*j+7] ? n[8*j +: 8] : o[8*j +: 8];
    return r;
  endfunction

  function automatic int unsigned tb_pop(input logic [W-1:0] d);
    int unsigned c;
    c = 0;
    for (int j = 0; j < PPB; j++) if (d[8*j+7]) c++;
    return c;
  endfunction

  // One clock: drive inputs, predict the edge, then check registered results.
  task automatic cyc(input logic sv, input logic [W-1:0] o, input logic [W-1:0] n,
                     input logic dv, input logic [W-1:0] d, input logic rdy,
                     input logic use_exp, input logic [W-1:0] ex);
    logic stall_m, pop_m, push_m;
    logic [2*W-1:0] pr;
    exp_t e;
    int unsigned pc;
    s_valid = sv; s_old = o; s_new = n; del_valid = dv; del = d; m_tready = rdy;
    stall_m = mv & ~rdy;
    #1;
    chk("stall", W'(stall), W'(stall_m));
    chk("s_ready", W'(s_ready), W'(!stall_m && mq.size() < DEPTH));
    pop_m  = dv && !stall_m && mq.size() != 0;
    push_m = sv && !stall_m && mq.size() < DEPTH;
    if (dv && !stall_m && mq.size() == 0) merr = 1'b1;
    mfcv = 1'b0;
    if (pop_m) begin
      pr = mq.pop_front();
      e.data = use_exp ? ex : tb_fuse(pr[2*W-1:W], pr[W-1:0], d);
      e.user = (mbeat == 0);
      e.last = (mbeat == BPF - 1);
      sb.push_back(e);
      pc   = tb_pop(d);
      macc = (mbeat == 0) ? pc : macc + pc;
      if (mbeat == BPF - 1) begin
        mfcv = 1'b1;
        mfc  = macc;
      end
      mbeat = (mbeat == BPF - 1) ? 0 : mbeat + 1;
    end
    if (push_m) mq.push_back({o, n});
    if (pop_m) mv = 1'b1;
    else if (rdy) mv = 1'b0;
    last_pop = pop_m;
    @(posedge clk);
    #1;
    chk("m_tvalid", W'(m_tvalid), W'(mv));
    chk("err_underflow", W'(err_underflow), W'(merr));
`ifdef HSSIM_FUSE_STATS_EN
    chk("frame_changes_valid", W'(frame_changes_valid), W'(mfcv));
    if (mfcv) chk("frame_changes", W'(frame_changes), W'(mfc));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic do_reset();
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_m_tvalid", W'(m_tvalid), '0);
    chk("rst_m_tuser", W'(m_tuser), '0);
    chk("rst_m_tlast", W'(m_tlast), '0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_err_underflow", W'(err_underflow), '0);
    chk("rst_stall", W'(stall), '0);
    chk("rst_s_ready", W'(s_ready), W'(1));
`ifdef HSSIM_FUSE_STATS_EN
    chk("rst_frame_changes", W'(frame_changes), '0);
    chk("rst_frame_changes_valid", W'(frame_changes_valid), '0);
`endif
    mq.delete(); sb.delete();
    mv = 1'b0; merr = 1'b0; mfcv = 1'b0; last_pop = 1'b0; mbeat = 0; macc = 0;
    s_valid = 1'b0; del_valid = 1'b0; m_tready = 1'b1;
    @(posedge clk);
    #3;
    aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Output monitor: transfers pop the scoreboard; stalled data must hold.
  logic         held = 1'b0;
  logic [W-1:0] hold_data;
  always @(negedge clk) begin : mon
    exp_t e;
    if (aresetn) begin
      if (held) chk("hold_data", m_tdata, hold_data);
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
        end else begin
          e = sb.pop_front();
          chk("m_tdata", m_tdata, e.data);
          chk("m_tuser", W'(m_tuser), W'(e.user));
          chk("m_tlast", W'(m_tlast), W'(e.last));
        end
      end
      held      = m_tvalid && !m_tready;
      hold_data = m_tdata;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[12];

  initial begin
    logic [W-1:0] d;
    int popped;
    int k;

    for (int i = 0; i < 10; i++) begin
      tbl[i].old_px = rnd();
      tbl[i].new_px = rnd();
      tbl[i].del    = '1;
      tbl[i].exp    = tbl[i].new_px;
    end
    for (int i = 10; i < 12; i++) begin
      tbl[i].old_px = {16{8'h11}};
      tbl[i].new_px = {16{8'hEE}};
      tbl[i].del    = {8{16'h00FF}};
      tbl[i].exp    = {8{16'h11EE}};
    end

    do_reset();

    // Vectors pushed back-to-back, decisions arriving five cycles behind.
    for (int c = 0; c < 17; c++) begin
      int di;
      di = (c >= 5) ? c - 5 : 0;
      cyc(c < 12, (c < 12) ? tbl[c % 12].old_px : '0, (c < 12) ? tbl[c % 12].new_px : '0,
          c >= 5, tbl[di].del, 1'b1, 1'b1, tbl[di].exp);
    end
    idle(3);

    // Backpressure for four cycles mid-stream; decision held while stalled.
    for (int i = 0; i < 6; i++) cyc(1'b1, rnd(), rnd(), 1'b0, '0, 1'b1, 1'b0, '0);
    popped = 0;
    k = 0;
    d = rnd();
    while (popped < 6 && k < 40) begin
      if (k > 0 && last_pop) d = rnd();
      cyc(1'b0, '0, '0, 1'b1, d, !(k >= 2 && k < 6), 1'b0, '0);
      if (last_pop) popped++;
      k++;
    end
    chk("stall_beats_popped", W'(popped), W'(6));
    idle(3);

    // Fill past capacity: the beat offered at count==FIFO_DEPTH is refused.
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, rnd(), rnd(), 1'b0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, '0, 1'b1, rnd(), 1'b1, 1'b0, '0);
    idle(2);

    // Decision with nothing stored: sticky error, no output.
    cyc(1'b0, '0, '0, 1'b1, '1, 1'b1, 1'b0, '0);
    idle(3);

    // Full frame plus two beats of the next, three changed bytes per beat.
    do_reset();
    for (int c = 0; c < BPF + 4; c++) begin
      cyc(c < BPF + 2, rnd(), rnd(), c >= 2, W'(24'hFF_FFFF), 1'b1, 1'b0, '0);
    end
    idle(3);

    // Reset with six entries stored and an output beat waiting.
    for (int i = 0; i < 7; i++) cyc(1'b1, rnd(), rnd(), 1'b0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b1, rnd(), 1'b0, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cyc(c < 2, rnd(), rnd(), c >= 2, rnd(), 1'b1, 1'b0, '0);
    end
    idle(3);

    chk("scoreboard_drained", W'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hssim_fuse.md
# hssim_fuse

Downstream consumer of the HSSIM decision stream. Holds the original old/new pixel beats in a FIFO while HSSIM computes each beat's per-pixel decision map (`del`, 0 or 255). When that beat's `del` arrives, it pops the matching pixels and emits the fused beat (new pixel where `del`=255, old pixel otherwise) on a ready/valid output stream with frame markers. It also generates the `stall` that freezes the HSSIM pipeline under output backpressure.

## Interface
- `PIXELS_PER_BEAT`, 16, pixels per beat, 8 bits each
- `IMAGE_DIM`, 512, square frame side in pixels; `IMAGE_DIM*IMAGE_DIM` divisible by `PIXELS_PER_BEAT`
- `FIFO_DEPTH`, 32, pixel-pair entries; must be ≥ HSSIM latency + 2
- `clk` in 1: single clock
- `aresetn` in 1: reset, asynchronous, active-low
- `s_valid` in 1: pixel beat valid
- `s_ready` out 1: pixel beat accepted when `s_valid & s_ready`
- `s_old` in 8·PPB: old-frame pixels
- `s_new` in 8·PPB: new-frame pixels
- `del_valid` in 1: `del` holds a valid decision beat
- `del` in 8·PPB: HSSIM decision, each byte 0x00 or 0xFF
- `stall` out 1: freeze to HSSIM and its valid tracker
- `m_tvalid` out 1, `m_tready` in 1, `m_tdata` out 8·PPB: fused output
- `m_tuser` out 1: first beat of frame; `m_tlast` out 1: last beat of frame
- `err_underflow` out 1: sticky, decision arrived with no stored pixels

## Operation
- `stall = m_tvalid & ~m_tready`.
- `s_ready = ~stall & (count < FIFO_DEPTH)`. A push writes `{s_old, s_new}`.
- Pop condition: `del_valid & ~stall & (count != 0)`. On pop, for each pixel j: `m_tdata[j] <= del[j][7] ? new[j] : old[j]`. Only bit 7 of each `del` byte is used. `m_tvalid <= 1`.
- `m_tvalid` clears on `m_tready` in a cycle with no pop. Pop while `m_tvalid & m_tready` reloads back-to-back with no bubble.
- Simultaneous push and pop: `count` is unchanged; pointers wrap modulo `FIFO_DEPTH`. There is no bypass: an entry is poppable only from the cycle after its push.
- Underflow: `del_valid & ~stall & count==0` sets `err_underflow`. No pop, no output, and the beat is dropped. The flag clears only on reset.
- Beat counter runs 0 .. BEATS_PER_FRAME−1 and increments on each pop, wrapping to 0. `m_tuser`/`m_tlast` are registered with `m_tdata`: `m_tuser` is set for count 0, `m_tlast` for BEATS_PER_FRAME−1.
- Reset (async, any time, including mid-frame): pointers, count, and beat counter go to 0. `m_tvalid`, `m_tuser`, `m_tlast`, `m_tdata`, `err_underflow`, and the stats outputs all go to 0. `stall` is therefore 0 and `s_ready` is 1 out of reset.

## Timing
- Decision-to-output: 1 cycle (pop at edge N, `m_tvalid` high after edge N).
- Pixel-to-output: HSSIM latency + 1 cycle.
- `stall` is combinational from `m_tvalid`/`m_tready`.
- `s_ready` is combinational from `stall` and the registered `count`.
- Throughput: 1 beat/cycle with `m_tready` held high.
- While `stall`=1, upstream holds `del`/`del_valid` stable; the block neither pops nor pushes.

## Configuration
- `HSSIM_FUSE_STATS_EN` defined: adds two outputs.
  - `frame_changes`, width `$clog2(IMAGE_DIM*IMAGE_DIM+1)`: the count of pixels with `del[j][7]`=1 over the frame.
  - `frame_changes_valid`: 1-cycle pulse, issued the cycle after the pop of the last beat.
  - The accumulator restarts at 0 on the first beat of each frame.
- Undefined: ports and logic absent; all other behaviour identical.

## Structure
- Shared package `hssim_pkg`:
  - `BEATS_PER_FRAME` computation function
  - pixel/beat width constants
  - popcount function used by stats
- One sub-module: `hssim_pair_fifo`, a synchronous FIFO with `count` output, no bypass, width 16·PPB, parameter `FIFO_DEPTH`.
- Fuse mux, frame counter, and stats stay in the top module.

## Test plan
- Ten beats pushed; `del_valid` for those beats 5 cycles later with `del`=all 0xFF, `m_tready`=1 → `m_tdata`=`s_new` per beat, one beat per cycle, `err_underflow`=0.
- Alternating `del` bytes 0xFF/0x00, old=0x11.., new=0xEE.. → `m_tdata` bytes alternate 0xEE/0x11.
- `m_tready` low for 4 cycles mid-stream → `stall`=1 for those cycles, `m_tdata` stable, no beat lost or duplicated, `count` constant.
- Full frame (IMAGE_DIM=32, PPB=16, 64 beats) → `m_tuser` on beat 0, `m_tlast` on beat 63, counter wraps to 0 for the next frame. With `HSSIM_FUSE_STATS_EN` and 3 set bytes per beat, `frame_changes`=192.
- `del_valid` with empty FIFO → `err_underflow`=1 and stays set, `m_tvalid` remains 0.
- `aresetn` pulsed low with 6 entries stored and `m_tvalid`=1 → all outputs 0 immediately, `s_ready`=1; next frame starts with `m_tuser` on its first beat.
